// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter that merges the instruction-fetch read port and the
// data read/write port onto one line-wide memory port, alternating under contention.
module mem_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 12,
  parameter int SEL_W  = LINE_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch port (read only)
  input  logic              if_read,
  input  logic [ADDR_W-1:0] if_address,
  output logic [LINE_W-1:0] if_rdata,
  output logic              if_resp,
  // data port
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic [SEL_W-1:0]  d_sel,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // downstream memory port
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic [SEL_W-1:0]  pmem_sel,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  // FSM state, for observation only
  output logic [1:0]        dbg_state
);

  // Handshake: an upstream request is a level held until its one-cycle resp pulse;
  // the downstream strobe is likewise held from grant until the one-cycle pmem_resp,
  // and pmem_resp is only honoured while a grant is outstanding.

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GRANT_IF = 2'd1;
  localparam logic [1:0] GRANT_D  = 2'd2;

  localparam logic LG_IF = 1'b0;
  localparam logic LG_D  = 1'b1;

  logic [1:0]        state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [LINE_W-1:0] wdata_q,      wdata_d;
  logic [SEL_W-1:0]  sel_q,        sel_d;
  logic              is_write_q,   is_write_d;

  logic d_req;
  logic grant_d_now;

  assign d_req = d_read | d_write;
  // Data wins ties unless it was also the previous winner and ifetch is waiting.
  assign grant_d_now = d_req && (!if_read || (last_grant_q == LG_IF));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    is_write_d   = is_write_q;

    case (state_q)
      IDLE: begin
        if (grant_d_now) begin
          state_d    = GRANT_D;
          addr_d     = d_address;
          is_write_d = d_write;
          if (d_write) begin
            wdata_d = d_wdata;
            sel_d   = d_sel;
          end else begin
            wdata_d = '0;
            sel_d   = '1;
          end
        end else if (if_read) begin
          state_d    = GRANT_IF;
          addr_d     = if_address;
          is_write_d = 1'b0;
          wdata_d    = '0;
          sel_d      = '1;
        end
      end
      GRANT_IF: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = LG_IF;
        end
      end
      GRANT_D: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = LG_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LG_IF;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      is_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      is_write_q   <= is_write_d;
    end
  end

  // Strobes decode straight from state so they drop the moment reset asserts.
  assign pmem_read    = (state_q == GRANT_IF) || ((state_q == GRANT_D) && !is_write_q);
  assign pmem_write   = (state_q == GRANT_D) && is_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_sel     = sel_q;

  assign if_resp  = (state_q == GRANT_IF) && pmem_resp;
  assign d_resp   = (state_q == GRANT_D) && pmem_resp;
  assign if_rdata = if_resp ? pmem_rdata : '0;
  assign d_rdata  = d_resp  ? pmem_rdata : '0;

  assign dbg_state = state_q;

endmodule
